// File: rtl/dft_out_buf_if.sv
// Stream ports of the DFT output buffer: a sample input side without backpressure
// and a ready/valid output side.
interface dft_out_buf_if #(parameter int DW = 16);
    logic                 block_sync_i;
    logic                 data_val_i;
    logic signed [DW-1:0] data_real_i;
    logic signed [DW-1:0] data_imag_i;
    logic [11:0]          trans_len_i;
    logic [10:0]          data_index_i;
    logic                 out_ready_i;
    logic                 out_valid_o;
    logic signed [DW-1:0] out_real_o;
    logic signed [DW-1:0] out_imag_o;
    logic                 out_first_o;
    logic                 out_last_o;
    logic [11:0]          out_len_o;
    logic                 ovf_o;
    logic                 err_o;

    modport slave (
        input  block_sync_i, data_val_i, data_real_i, data_imag_i, trans_len_i, data_index_i, out_ready_i,
        output out_valid_o, out_real_o, out_imag_o, out_first_o, out_last_o, out_len_o, ovf_o, err_o
    );
    modport master (
        output block_sync_i, data_val_i, data_real_i, data_imag_i, trans_len_i, data_index_i, out_ready_i,
        input  out_valid_o, out_real_o, out_imag_o, out_first_o, out_last_o, out_len_o, ovf_o, err_o
    );
endinterface

// File: rtl/dft_out_buf.sv
// Ping-pong reorder buffer: DFT samples land by frequency index in one bank while the
// other bank streams out in natural order over ready/valid.
module dft_out_buf #(
    parameter int DW    = 16,
    parameter int DEPTH = 2048
) (
    input logic          clk_sys,
    input logic          rst_sys,
    dft_out_buf_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [12:0] MAX_LEN = 13'(DEPTH);

    typedef enum logic [1:0] {IDLE, FETCH, SEND} rd_state_t;

    logic [2*DW-1:0] mem0 [DEPTH];
    logic [2*DW-1:0] mem1 [DEPTH];

    logic             wr_bank_q, wr_bank_d;
    logic             wr_act_q, wr_act_d;
    logic [11:0]      wr_len_q, wr_len_d;
    logic [11:0]      wr_cnt_q, wr_cnt_d;
    logic [1:0]       full_q, full_d;
    logic [1:0][11:0] bank_len_q, bank_len_d;
    logic             err_q, err_d, ovf_q, ovf_d;
    logic             start, take, we;
    logic [11:0]      len_cur, cnt_nxt;
    logic [1:0]       set_full, clr_full;

    rd_state_t        state_q, state_d;
    logic             rd_bank_q, rd_bank_d;
    logic [AW-1:0]    ra_q, ra_d, ra;
    logic             re;
    logic             vld_q, vld_d, first_q, first_d, last_q, last_d;
    logic [11:0]      olen_q, olen_d;
    logic [2*DW-1:0]  odat_q, odat_d;

    assign start = bus.block_sync_i & bus.data_val_i;

    always_comb begin
        wr_bank_d  = wr_bank_q;
        wr_act_d   = wr_act_q;
        wr_len_d   = wr_len_q;
        wr_cnt_d   = wr_cnt_q;
        bank_len_d = bank_len_q;
        err_d      = 1'b0;
        ovf_d      = 1'b0;
        we         = 1'b0;
        take       = 1'b0;
        len_cur    = wr_len_q;
        cnt_nxt    = wr_cnt_q + 12'd1;
        set_full   = 2'b00;
        if (start) begin
            // a start always abandons any partial block in progress
            err_d    = wr_act_q;
            wr_act_d = 1'b0;
            if (bus.trans_len_i == 12'd0 || {1'b0, bus.trans_len_i} > MAX_LEN) begin
                err_d = 1'b1;
            end else if (full_q[wr_bank_q]) begin
                ovf_d = 1'b1;
            end else begin
                take    = 1'b1;
                len_cur = bus.trans_len_i;
                cnt_nxt = 12'd1;
            end
        end else if (bus.data_val_i && wr_act_q) begin
            take = 1'b1;
        end
        if (take) begin
            wr_act_d = 1'b1;
            wr_len_d = len_cur;
            wr_cnt_d = cnt_nxt;
            if ({1'b0, bus.data_index_i} < len_cur) we = 1'b1;
            else                                    err_d = 1'b1;
            if (cnt_nxt == len_cur) begin
                set_full[wr_bank_q]   = 1'b1;
                bank_len_d[wr_bank_q] = len_cur;
                wr_bank_d             = ~wr_bank_q;
                wr_act_d              = 1'b0;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        rd_bank_d = rd_bank_q;
        ra_d      = ra_q;
        vld_d     = vld_q;
        first_d   = first_q;
        last_d    = last_q;
        olen_d    = olen_q;
        clr_full  = 2'b00;
        re        = 1'b0;
        ra        = ra_q;
        case (state_q)
            IDLE: if (full_q[rd_bank_q]) state_d = FETCH;
            FETCH: begin
                re      = 1'b1;
                ra      = '0;
                ra_d    = '0 + 1'b1;
                vld_d   = 1'b1;
                first_d = 1'b1;
                last_d  = (bank_len_q[rd_bank_q] == 12'd1);
                olen_d  = bank_len_q[rd_bank_q];
                state_d = SEND;
            end
            SEND: if (bus.out_ready_i) begin
                if (last_q) begin
                    clr_full[rd_bank_q] = 1'b1;
                    rd_bank_d = ~rd_bank_q;
                    vld_d     = 1'b0;
                    first_d   = 1'b0;
                    last_d    = 1'b0;
                    state_d   = full_q[~rd_bank_q] ? FETCH : IDLE;
                end else begin
                    // ra_q already points at the next index, so data is ready every cycle
                    re      = 1'b1;
                    ra_d    = ra_q + 1'b1;
                    first_d = 1'b0;
                    last_d  = (12'(ra_q) == olen_q - 12'd1);
                end
            end
            default: state_d = IDLE;
        endcase
        odat_d = odat_q;
        if (re) odat_d = rd_bank_q ? mem1[ra] : mem0[ra];
    end

    assign full_d = (full_q | set_full) & ~clr_full;

    always_ff @(posedge clk_sys) begin
        if (we && !wr_bank_q) mem0[bus.data_index_i[AW-1:0]] <= {bus.data_real_i, bus.data_imag_i};
        if (we &&  wr_bank_q) mem1[bus.data_index_i[AW-1:0]] <= {bus.data_real_i, bus.data_imag_i};
    end

    always_ff @(posedge clk_sys or posedge rst_sys) begin
        if (rst_sys) begin
            wr_bank_q  <= 1'b0;
            wr_act_q   <= 1'b0;
            wr_len_q   <= '0;
            wr_cnt_q   <= '0;
            full_q     <= '0;
            bank_len_q <= '0;
            err_q      <= 1'b0;
            ovf_q      <= 1'b0;
            state_q    <= IDLE;
            rd_bank_q  <= 1'b0;
            ra_q       <= '0;
            vld_q      <= 1'b0;
            first_q    <= 1'b0;
            last_q     <= 1'b0;
            olen_q     <= '0;
            odat_q     <= '0;
        end else begin
            wr_bank_q  <= wr_bank_d;
            wr_act_q   <= wr_act_d;
            wr_len_q   <= wr_len_d;
            wr_cnt_q   <= wr_cnt_d;
            full_q     <= full_d;
            bank_len_q <= bank_len_d;
            err_q      <= err_d;
            ovf_q      <= ovf_d;
            state_q    <= state_d;
            rd_bank_q  <= rd_bank_d;
            ra_q       <= ra_d;
            vld_q      <= vld_d;
            first_q    <= first_d;
            last_q     <= last_d;
            olen_q     <= olen_d;
            odat_q     <= odat_d;
        end
    end

    assign bus.out_valid_o = vld_q;
    assign bus.out_real_o  = odat_q[2*DW-1:DW];
    assign bus.out_imag_o  = odat_q[DW-1:0];
    assign bus.out_first_o = first_q;
    assign bus.out_last_o  = last_q;
    assign bus.out_len_o   = olen_q;
    assign bus.ovf_o       = ovf_q;
    assign bus.err_o       = err_q;
endmodule

// File: tb/tb_dft_out_buf.sv
// Directed bench for dft_out_buf: reorder, overflow, restart, illegal length,
// stalls under random ready and reset mid-emission.
module tb_dft_out_buf;
    localparam int DW = 16;

    logic clk_sys = 1'b0;
    logic rst_sys;
    always #5 clk_sys = ~clk_sys;

    dft_out_buf_if #(.DW(DW)) bus ();
    dft_out_buf #(.DW(DW), .DEPTH(2048)) dut (.clk_sys(clk_sys), .rst_sys(rst_sys), .bus(bus));

    typedef struct {
        logic          first;
        logic          last;
        logic [11:0]   len;
        logic [DW-1:0] re;
        logic [DW-1:0] im;
    } rec_t;

    int   n_cmp = 0;
    int   n_err = 0;
    rec_t q[$];
    rec_t held, cur;
    logic stall_prev = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // transfers are logged at the falling edge; a stalled beat must repeat unchanged
    always @(negedge clk_sys) begin
        if (rst_sys) begin
            stall_prev = 1'b0;
        end else begin
            cur.first = bus.out_first_o;
            cur.last  = bus.out_last_o;
            cur.len   = bus.out_len_o;
            cur.re    = bus.out_real_o;
            cur.im    = bus.out_imag_o;
            if (stall_prev) begin
                chk("hold_valid", 32'(bus.out_valid_o), 32'd1);
                chk("hold_data", {cur.re, cur.im}, {held.re, held.im});
                chk("hold_mark", 32'({cur.first, cur.last, cur.len}), 32'({held.first, held.last, held.len}));
            end
            if (bus.out_valid_o && bus.out_ready_i) q.push_back(cur);
            stall_prev = bus.out_valid_o && !bus.out_ready_i;
            held = cur;
        end
    end

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic put(input logic sync, input int len, input int idx, input logic [DW-1:0] re, input logic [DW-1:0] im);
        bus.block_sync_i = sync;
        bus.data_val_i   = 1'b1;
        bus.trans_len_i  = 12'(len);
        bus.data_index_i = 11'(idx);
        bus.data_real_i  = re;
        bus.data_imag_i  = im;
        step();
        bus.block_sync_i = 1'b0;
        bus.data_val_i   = 1'b0;
    endtask

    task automatic wait_out(input int n, input int budget, input string tag);
        int c = 0;
        while (q.size() < n && c < budget) begin
            step();
            c++;
        end
        chk(tag, 32'(q.size()), 32'(n));
    endtask

    task automatic expect_rec(input string tag, input logic f, input logic l, input int len,
                              input logic [DW-1:0] re, input logic [DW-1:0] im);
        rec_t r;
        chk({tag, "_avail"}, 32'(q.size() > 0), 32'd1);
        if (q.size() > 0) begin
            r = q.pop_front();
            chk({tag, "_data"}, {r.re, r.im}, {re, im});
            chk({tag, "_mark"}, 32'({r.first, r.last, r.len}), 32'({f, l, 12'(len)}));
        end
    endtask

    initial begin
        rec_t r;
        int   c;
        rst_sys          = 1'b1;
        bus.block_sync_i = 1'b0;
        bus.data_val_i   = 1'b0;
        bus.data_real_i  = '0;
        bus.data_imag_i  = '0;
        bus.trans_len_i  = '0;
        bus.data_index_i = '0;
        bus.out_ready_i  = 1'b0;
        repeat (3) @(posedge clk_sys);
        #1;
        chk("rst_valid", 32'(bus.out_valid_o), 32'd0);
        chk("rst_marks", 32'({bus.out_first_o, bus.out_last_o}), 32'd0);
        chk("rst_events", 32'({bus.ovf_o, bus.err_o}), 32'd0);
        chk("rst_data", {bus.out_real_o, bus.out_imag_o}, 32'd0);
        chk("rst_len", 32'(bus.out_len_o), 32'd0);
        rst_sys = 1'b0;
        step();

        // len 12 written in reverse index order, read back naturally
        bus.out_ready_i = 1'b1;
        for (int i = 0; i < 12; i++) put(i == 0, 12, 11 - i, 16'(11 - i), 16'(256 + 11 - i));
        chk("t1_lat_n", 32'(bus.out_valid_o), 32'd0);
        step();
        chk("t1_lat_n1", 32'(bus.out_valid_o), 32'd0);
        step();
        chk("t1_lat_n2", 32'(bus.out_valid_o), 32'd1);
        chk("t1_lat_first", 32'({bus.out_first_o, bus.out_real_o}), 32'h10000);
        wait_out(12, 40, "t1_count");
        for (int i = 0; i < 12; i++) expect_rec("t1", i == 0, i == 11, 12, 16'(i), 16'(256 + i));

        // illegal lengths and stray samples while idle
        put(1'b1, 0, 0, 16'd1, 16'd1);
        chk("t2_err_len0", 32'({bus.err_o, bus.ovf_o}), 32'b10);
        step();
        chk("t2_err_pulse", 32'(bus.err_o), 32'd0);
        put(1'b1, 2049, 0, 16'd1, 16'd1);
        chk("t2_err_len2049", 32'(bus.err_o), 32'd1);
        put(1'b0, 0, 1, 16'd1, 16'd1);
        chk("t2_stray_noerr", 32'(bus.err_o), 32'd0);
        repeat (10) step();
        chk("t2_no_output", 32'(q.size()), 32'd0);
        chk("t2_valid_low", 32'(bus.out_valid_o), 32'd0);

        // restart after 10 samples discards the partial block
        for (int i = 0; i < 10; i++) put(i == 0, 24, i, 16'(500 + i), 16'(600 + i));
        put(1'b1, 24, 0, 16'd0, 16'h300);
        chk("t3_err_restart", 32'(bus.err_o), 32'd1);
        for (int i = 1; i < 24; i++) put(1'b0, 24, i, 16'(i), 16'(16'h300 + i));
        wait_out(24, 60, "t3_count");
        for (int i = 0; i < 24; i++) expect_rec("t3", i == 0, i == 23, 24, 16'(i), 16'(16'h300 + i));
        repeat (5) step();
        chk("t3_no_extra", 32'(q.size()), 32'd0);

        // out-of-range index is dropped but still counts toward the length
        put(1'b1, 4, 0, 16'h40, 16'h50);
        put(1'b0, 4, 1, 16'h41, 16'h51);
        put(1'b0, 4, 5, 16'h45, 16'h55);
        chk("t3b_err_idx", 32'(bus.err_o), 32'd1);
        put(1'b0, 4, 3, 16'h43, 16'h53);
        chk("t3b_err_clear", 32'(bus.err_o), 32'd0);
        wait_out(4, 30, "t3b_count");
        expect_rec("t3b_0", 1'b1, 1'b0, 4, 16'h40, 16'h50);
        expect_rec("t3b_1", 1'b0, 1'b0, 4, 16'h41, 16'h51);
        r = q.pop_front();
        chk("t3b_2_mark", 32'({r.first, r.last, r.len}), 32'({2'b00, 12'd4}));
        expect_rec("t3b_3", 1'b0, 1'b1, 4, 16'h43, 16'h53);

        // single-sample block
        put(1'b1, 1, 0, 16'h77, 16'h88);
        wait_out(1, 20, "len1_count");
        expect_rec("len1", 1'b1, 1'b1, 1, 16'h77, 16'h88);

        // two full-size blocks with ready low, third start overflows
        bus.out_ready_i = 1'b0;
        for (int b = 0; b < 2; b++)
            for (int i = 0; i < 2048; i++) put(i == 0, 2048, i, 16'(b * 16'h4000 + i), 16'(16'hffff - i));
        put(1'b1, 16, 0, 16'h1234, 16'h1234);
        chk("t4_ovf", 32'({bus.ovf_o, bus.err_o}), 32'b10);
        for (int i = 1; i < 16; i++) put(1'b0, 16, i, 16'h1234, 16'h1234);
        chk("t4_ovf_pulse", 32'(bus.ovf_o), 32'd0);
        chk("t4_none_yet", 32'(q.size()), 32'd0);
        bus.out_ready_i = 1'b1;
        wait_out(4096, 4400, "t4_count");
        for (int b = 0; b < 2; b++)
            for (int i = 0; i < 2048; i++)
                expect_rec("t4", i == 0, i == 2047, 2048, 16'(b * 16'h4000 + i), 16'(16'hffff - i));
        repeat (20) step();
        chk("t4_dropped", 32'(q.size()), 32'd0);

        // random ready on a len 300 block
        bus.out_ready_i = 1'b0;
        for (int i = 0; i < 300; i++) put(i == 0, 300, i, 16'(i * 3), 16'(i));
        c = 0;
        while (q.size() < 300 && c < 3000) begin
            bus.out_ready_i = 1'($urandom_range(0, 1));
            step();
            c++;
        end
        chk("t5_count", 32'(q.size()), 32'd300);
        bus.out_ready_i = 1'b1;
        for (int i = 0; i < 300; i++) expect_rec("t5", i == 0, i == 299, 300, 16'(i * 3), 16'(i));
        repeat (10) step();
        chk("t5_no_dup", 32'(q.size()), 32'd0);

        // reset in the middle of emitting a len 96 block
        for (int i = 0; i < 96; i++) put(i == 0, 96, i, 16'(16'h500 + i), 16'(i));
        wait_out(40, 200, "t6_partial");
        rst_sys = 1'b1;
        #1;
        chk("t6_rst_valid", 32'(bus.out_valid_o), 32'd0);
        chk("t6_rst_data", {bus.out_real_o, bus.out_imag_o}, 32'd0);
        chk("t6_rst_marks", 32'({bus.out_first_o, bus.out_last_o, bus.out_len_o}), 32'd0);
        step();
        rst_sys = 1'b0;
        q.delete();
        step();
        for (int i = 0; i < 16; i++) put(i == 0, 16, i, 16'(16'h700 + i), 16'(16'h10 + i));
        wait_out(16, 40, "t6_count");
        for (int i = 0; i < 16; i++) expect_rec("t6", i == 0, i == 15, 16, 16'(16'h700 + i), 16'(16'h10 + i));
        repeat (20) step();
        chk("t6_no_stale", 32'(q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
